// File: rtl/io_seq_pkg.sv
// Shared types for the I/O handshake sequencer: FSM states, request modes and the mode decoder.
package io_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitRelease,
    StWaitPress,
    StFire,
    StCooldown
  } state_e;

  typedef enum logic [1:0] {
    ModeNone,
    ModeOutput,
    ModeInput,
    ModePause
  } mode_e;

  function automatic mode_e decode_mode(input logic is_input, input logic is_output);
    mode_e mode;
    unique case ({is_input, is_output})
      2'b01:   mode = ModeOutput;
      2'b10:   mode = ModeInput;
      2'b11:   mode = ModePause;
      default: mode = ModeNone;
    endcase
    return mode;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus counter debounce for one push-button; emits a one-cycle press
// pulse on each accepted rising edge.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic press_o
);

  localparam int unsigned CntWidth = $clog2(DEBOUNCE_CYCLES + 1);

  logic                sync1_q;
  logic                sync2_q;
  logic                level_q;
  logic                press_q;
  logic [CntWidth-1:0] cnt_q;
  logic [CntWidth-1:0] cnt_inc;

  assign cnt_inc = cnt_q + CntWidth'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_inc == CntWidth'(DEBOUNCE_CYCLES)) begin
        // Accept the new level on the edge the count is reached; flag only rising edges.
        cnt_q   <= '0;
        level_q <= ~level_q;
        press_q <= ~level_q;
      end else begin
        cnt_q <= cnt_inc;
      end
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/io_handshake_sequencer.sv
// Front-end between board buttons/switches and the core's OUTPUT/INPUT/PAUSE instructions:
// one confirmation or continue pulse per instruction, with switch capture and display hold.
module io_handshake_sequencer
  import io_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned SWITCH_WIDTH    = 16,
  parameter int unsigned DATA_WIDTH      = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    is_input,
  input  logic                    is_output,
  input  logic                    raw_confirm,
  input  logic                    raw_continue,
  input  logic [SWITCH_WIDTH-1:0] switches,
  input  logic [DATA_WIDTH-1:0]   output_value,
  output logic                    confirmation,
  output logic                    continue_button,
  output logic [DATA_WIDTH-1:0]   input_value,
  output logic [DATA_WIDTH-1:0]   display_value,
  output logic                    waiting
);

  logic [SWITCH_WIDTH-1:0] sw_sync1_q;
  logic [SWITCH_WIDTH-1:0] sw_sync2_q;
  logic                    confirm_level;
  logic                    confirm_press;
  logic                    continue_level;
  logic                    continue_press;
  logic                    sel_level;
  logic                    sel_press;
  mode_e                   live_mode;
  mode_e                   mode_q;
  state_e                  state_q;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_confirm_db (
    .clock  (clock),
    .reset  (reset),
    .raw_i  (raw_confirm),
    .level_o(confirm_level),
    .press_o(confirm_press)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_continue_db (
    .clock  (clock),
    .reset  (reset),
    .raw_i  (raw_continue),
    .level_o(continue_level),
    .press_o(continue_press)
  );

  assign live_mode = decode_mode(is_input, is_output);
  // Only the button belonging to the stored mode can advance the handshake.
  assign sel_level = (mode_q == ModePause) ? continue_level : confirm_level;
  assign sel_press = (mode_q == ModePause) ? continue_press : confirm_press;

  always_ff @(posedge clock) begin
    if (reset) begin
      sw_sync1_q <= '0;
      sw_sync2_q <= '0;
    end else begin
      sw_sync1_q <= switches;
      sw_sync2_q <= sw_sync1_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= StIdle;
      mode_q          <= ModeNone;
      confirmation    <= 1'b0;
      continue_button <= 1'b0;
      waiting         <= 1'b0;
      input_value     <= '0;
      display_value   <= '0;
    end else begin
      confirmation    <= 1'b0;
      continue_button <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (live_mode != ModeNone) begin
            state_q <= StWaitRelease;
            mode_q  <= live_mode;
            waiting <= 1'b1;
            if (live_mode == ModeOutput) display_value <= output_value;
          end
        end
        StWaitRelease: begin
          if (live_mode != mode_q) begin
            state_q <= StIdle;
            waiting <= 1'b0;
          end else if (!sel_level) begin
            state_q <= StWaitPress;
          end
        end
        StWaitPress: begin
          if (live_mode != mode_q) begin
            state_q <= StIdle;
            waiting <= 1'b0;
          end else if (sel_press) begin
            state_q <= StFire;
            waiting <= 1'b0;
            if (mode_q == ModePause) continue_button <= 1'b1;
            else                     confirmation    <= 1'b1;
            if (mode_q == ModeInput) input_value <= DATA_WIDTH'(sw_sync2_q);
          end
        end
        StFire:     state_q <= StCooldown;
        StCooldown: state_q <= StIdle;
        default:    state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_io_handshake_sequencer.sv
// Scoreboard bench for io_handshake_sequencer: stimulus queues expected pulses, a negedge
// monitor checks every pulse the DUT emits against the queue.
module tb_io_handshake_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        is_input;
  logic        is_output;
  logic        raw_confirm;
  logic        raw_continue;
  logic [15:0] switches;
  logic [31:0] output_value;
  logic        confirmation;
  logic        continue_button;
  logic [31:0] input_value;
  logic [31:0] display_value;
  logic        waiting;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  typedef struct {
    logic        is_cont;
    logic [31:0] in_val;
    logic [31:0] disp;
    int          at;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  io_handshake_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .SWITCH_WIDTH   (16),
    .DATA_WIDTH     (32)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .is_input       (is_input),
    .is_output      (is_output),
    .raw_confirm    (raw_confirm),
    .raw_continue   (raw_continue),
    .switches       (switches),
    .output_value   (output_value),
    .confirmation   (confirmation),
    .continue_button(continue_button),
    .input_value    (input_value),
    .display_value  (display_value),
    .waiting        (waiting)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Expected pulse appears `delay` edges after the current one (button edge -> 7 at default).
  task automatic expect_pulse(input logic is_cont, input logic [31:0] in_val,
                              input logic [31:0] disp, input int delay);
    exp_t e;
    e.is_cont = is_cont;
    e.in_val  = in_val;
    e.disp    = disp;
    e.at      = cyc + delay;
    exp_q.push_back(e);
  endtask

  always @(negedge clock) begin
    if (!reset && (confirmation || continue_button)) begin
      check("pulse_exclusive", 32'(confirmation & continue_button), 32'd0);
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_pulse: got confirmation=%0b continue=%0b at cycle %0d, want none",
                 confirmation, continue_button, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_kind_continue", 32'(continue_button), 32'(mon_e.is_cont));
        check("input_value", input_value, mon_e.in_val);
        check("display_value", display_value, mon_e.disp);
        check("pulse_cycle", cyc, mon_e.at);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t, want finished", $time);
    $fatal(1, "timeout");
  end

  initial begin
    reset        = 1'b1;
    is_input     = 1'b0;
    is_output    = 1'b0;
    raw_confirm  = 1'b0;
    raw_continue = 1'b0;
    switches     = 16'h0000;
    output_value = 32'h0;
    tick(3);
    check("reset_confirmation", 32'(confirmation), 32'd0);
    check("reset_continue", 32'(continue_button), 32'd0);
    check("reset_waiting", 32'(waiting), 32'd0);
    check("reset_input_value", input_value, 32'd0);
    check("reset_display_value", display_value, 32'd0);
    reset = 1'b0;
    tick(2);

    // OUTPUT with confirm pressed together with the request.
    output_value = 32'h0000_00A5;
    is_output    = 1'b1;
    raw_confirm  = 1'b1;
    expect_pulse(1'b0, 32'h0, 32'hA5, 7);
    tick(1);
    check("out_display_latched", display_value, 32'hA5);
    check("out_waiting_high", 32'(waiting), 32'd1);
    tick(6);
    check("out_confirmation_now", 32'(confirmation), 32'd1);
    check("out_waiting_falls", 32'(waiting), 32'd0);
    is_output   = 1'b0;
    raw_confirm = 1'b0;
    tick(10);

    // INPUT captures synced switches.
    switches = 16'hBEEF;
    tick(3);
    is_input    = 1'b1;
    raw_confirm = 1'b1;
    expect_pulse(1'b0, 32'h0000_BEEF, 32'hA5, 7);
    tick(7);
    is_input    = 1'b0;
    raw_confirm = 1'b0;
    tick(10);

    // PAUSE: confirm is ignored, continue fires.
    is_input    = 1'b1;
    is_output   = 1'b1;
    raw_confirm = 1'b1;
    tick(12);
    check("pause_waiting_after_confirm", 32'(waiting), 32'd1);
    raw_continue = 1'b1;
    expect_pulse(1'b1, 32'h0000_BEEF, 32'hA5, 7);
    tick(7);
    is_input     = 1'b0;
    is_output    = 1'b0;
    raw_confirm  = 1'b0;
    raw_continue = 1'b0;
    tick(10);

    // Held confirm must not retire a second INPUT until released and pressed again.
    switches = 16'h1234;
    tick(3);
    is_input    = 1'b1;
    raw_confirm = 1'b1;
    expect_pulse(1'b0, 32'h0000_1234, 32'hA5, 7);
    tick(7);
    switches = 16'h5678;
    tick(20);
    check("held_blocks_waiting", 32'(waiting), 32'd1);
    raw_confirm = 1'b0;
    tick(10);
    check("released_waiting", 32'(waiting), 32'd1);
    raw_confirm = 1'b1;
    expect_pulse(1'b0, 32'h0000_5678, 32'hA5, 7);
    tick(7);
    is_input    = 1'b0;
    raw_confirm = 1'b0;
    tick(10);

    // Bounce: 2-cycle toggling never qualifies; the settled press gives one pulse.
    output_value = 32'h1111_2222;
    is_output    = 1'b1;
    tick(3);
    for (int i = 0; i < 5; i++) begin
      raw_confirm = 1'b1;
      tick(2);
      raw_confirm = 1'b0;
      tick(2);
    end
    raw_confirm = 1'b1;
    expect_pulse(1'b0, 32'h0000_5678, 32'h1111_2222, 7);
    tick(7);
    is_output   = 1'b0;
    raw_confirm = 1'b0;
    tick(10);

    // Abort: drop the request while waiting for the press.
    output_value = 32'hDEAD_BEEF;
    is_output    = 1'b1;
    tick(4);
    check("abort_waiting_before", 32'(waiting), 32'd1);
    is_output = 1'b0;
    tick(1);
    check("abort_waiting_after", 32'(waiting), 32'd0);
    check("abort_display_kept", display_value, 32'hDEAD_BEEF);
    raw_confirm = 1'b1;
    tick(12);
    raw_confirm = 1'b0;
    tick(10);
    check("abort_input_kept", input_value, 32'h0000_5678);

    // Reset while waiting for the press.
    switches = 16'h9999;
    is_input = 1'b1;
    tick(4);
    check("rst_mid_waiting_before", 32'(waiting), 32'd1);
    reset = 1'b1;
    tick(1);
    check("rst_mid_confirmation", 32'(confirmation), 32'd0);
    check("rst_mid_continue", 32'(continue_button), 32'd0);
    check("rst_mid_waiting", 32'(waiting), 32'd0);
    check("rst_mid_input_value", input_value, 32'd0);
    check("rst_mid_display_value", display_value, 32'd0);
    is_input = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(5);

    check("pending_pulses_left", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
